// File: rtl/keypad_pkg.sv
// Shared types and constants for the scanned 4x4 hex keypad reader.
// Used by keypad_scanner and keypad_scan_entry.
package keypad_pkg;

  localparam int SNAP_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    SNAP_NONE  = 2'd0,
    SNAP_ONE   = 2'd1,
    SNAP_MULTI = 2'd2
  } snap_class_t;

  typedef struct packed {
    snap_class_t cls;
    logic [3:0]  code;
  } snap_info_t;

  // Snapshot bit 4*c+r (column c, row r) -> hex code printed on that key.
  localparam logic [3:0] KEY_MAP [SNAP_W] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  function automatic snap_info_t classify_snap(input logic [SNAP_W-1:0] snap);
    snap_info_t info;
    logic [4:0] ones;
    ones      = 5'd0;
    info.code = 4'h0;
    for (int i = 0; i < SNAP_W; i++) begin
      if (snap[i]) begin
        ones      = ones + 5'd1;
        info.code = KEY_MAP[i];
      end else begin
        ones = ones;
      end
    end
    case (ones)
      5'd0:    info.cls = SNAP_NONE;
      5'd1:    info.cls = SNAP_ONE;
      default: info.cls = SNAP_MULTI;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner: row synchroniser, slot timer, active-low column drive,
// 16-bit pressed-key snapshot and a one-cycle scan-done strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1250
) (
  input  logic              clk5,
  input  logic              reset,
  input  logic [3:0]        row,
  output logic [3:0]        col,
  output logic [SNAP_W-1:0] snapshot,
  output logic              scan_done
);

  localparam int            DW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] SLOT_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]        row_meta_r;
  logic [3:0]        row_sync_r;
  logic [DW-1:0]     slot_r;
  logic [1:0]        col_idx_r;
  logic [3:0]        col_r;
  logic [SNAP_W-1:0] snap_r;
  logic              scan_done_r;
  logic              slot_end_s;

  assign slot_end_s = (slot_r == SLOT_LAST);

  // Two-flop synchroniser for the asynchronous row lines (idle high).
  always_ff @(posedge clk5) begin
    if (reset) begin
      row_meta_r <= 4'b1111;
      row_sync_r <= 4'b1111;
    end else begin
      row_meta_r <= row;
      row_sync_r <= row_meta_r;
    end
  end

  // Slot timer, column rotation, snapshot capture and scan-done strobe.
  always_ff @(posedge clk5) begin
    if (reset) begin
      slot_r      <= '0;
      col_idx_r   <= 2'd0;
      col_r       <= 4'b1110;
      snap_r      <= '0;
      scan_done_r <= 1'b0;
    end else if (slot_end_s) begin
      slot_r                         <= '0;
      snap_r[{col_idx_r, 2'b00} +: 4] <= ~row_sync_r;
      col_idx_r                      <= col_idx_r + 2'd1;
      col_r                          <= ~(4'b0001 << (col_idx_r + 2'd1));
      scan_done_r                    <= (col_idx_r == 2'd3);
    end else begin
      slot_r      <= slot_r + DW'(1);
      scan_done_r <= 1'b0;
    end
  end

  assign col       = col_r;
  assign snapshot  = snap_r;
  assign scan_done = scan_done_r;

endmodule

// File: rtl/keypad_scan_entry.sv
// Keypad reader top: snapshot classifier, press/release debounce FSM and 16-bit entry register.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scan_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1250,
  parameter int DEBOUNCE_SCANS = 20,
  parameter int REPEAT_SCANS   = 500
) (
  input  logic        clk5,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        keyValid,
  output logic [3:0]  keyCode,
  output logic        keyHeld,
  output logic [15:0] entryVal
);

  localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_SCANS);

  logic [SNAP_W-1:0] snapshot_s;
  logic              scan_done_s;
  snap_info_t        info_s;

  kp_state_t   state_r, state_n;
  logic [3:0]  cand_r, cand_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic        held_r, held_n;
  logic        accept_s;
  logic [3:0]  accept_code_s;
  logic        key_valid_r;
  logic [3:0]  key_code_r;
  logic [15:0] entry_r;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int            RW       = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS);
  logic [RW-1:0] rep_r, rep_n;
`endif

  keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
    .clk5      (clk5),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .snapshot  (snapshot_s),
    .scan_done (scan_done_s)
  );

  assign info_s = classify_snap(snapshot_s);

  // Next-state logic; everything advances only on the scan-done strobe.
  always_comb begin
    state_n       = state_r;
    cand_n        = cand_r;
    cnt_n         = cnt_r;
    held_n        = held_r;
    accept_s      = 1'b0;
    accept_code_s = 4'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_n         = rep_r;
`endif
    if (scan_done_s) begin
      case (state_r)
        IDLE: begin
          if (info_s.cls == SNAP_ONE) begin
            cand_n  = info_s.code;
            cnt_n   = CW'(1);
            state_n = DEBOUNCE;
          end else begin
            state_n = IDLE;
          end
        end
        DEBOUNCE: begin
          if (info_s.cls == SNAP_ONE) begin
            if (info_s.code == cand_r) begin
              if ((cnt_r + CW'(1)) == DB_LAST) begin
                accept_s      = 1'b1;
                accept_code_s = cand_r;
                held_n        = 1'b1;
                state_n       = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_n         = '0;
`endif
              end else begin
                cnt_n = cnt_r + CW'(1);
              end
            end else begin
              cand_n = info_s.code;
              cnt_n  = CW'(1);
            end
          end else begin
            state_n = IDLE;
          end
        end
        PRESSED: begin
          if (info_s.cls == SNAP_NONE) begin
            cnt_n   = CW'(1);
            state_n = RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_n   = '0;
`endif
          end else begin
            state_n = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            // Only the original key held alone keeps the repeat timer running.
            if ((info_s.cls == SNAP_ONE) && (info_s.code == cand_r)) begin
              if ((rep_r + RW'(1)) == REP_LAST) begin
                rep_n         = '0;
                accept_s      = 1'b1;
                accept_code_s = cand_r;
              end else begin
                rep_n = rep_r + RW'(1);
              end
            end else begin
              rep_n = '0;
            end
`endif
          end
        end
        RELEASE: begin
          if (info_s.cls == SNAP_NONE) begin
            if ((cnt_r + CW'(1)) == DB_LAST) begin
              held_n  = 1'b0;
              state_n = IDLE;
            end else begin
              cnt_n = cnt_r + CW'(1);
            end
          end else begin
            state_n = PRESSED;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk5) begin
    if (reset) begin
      state_r     <= IDLE;
      cand_r      <= 4'h0;
      cnt_r       <= '0;
      held_r      <= 1'b0;
      key_valid_r <= 1'b0;
      key_code_r  <= 4'h0;
      entry_r     <= 16'h0000;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_r       <= '0;
`endif
    end else begin
      state_r     <= state_n;
      cand_r      <= cand_n;
      cnt_r       <= cnt_n;
      held_r      <= held_n;
      key_valid_r <= accept_s;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_r       <= rep_n;
`endif
      if (accept_s) begin
        key_code_r <= accept_code_s;
        entry_r    <= {entry_r[11:0], accept_code_s};
      end else begin
        key_code_r <= key_code_r;
        entry_r    <= entry_r;
      end
    end
  end

  assign keyValid = key_valid_r;
  assign keyCode  = key_code_r;
  assign keyHeld  = held_r;
  assign entryVal = entry_r;

endmodule

// File: tb/tb_keypad_scan_entry.sv
// Scoreboard bench for keypad_scan_entry: a keypad model drives the rows from col,
// expected accepts (code, entry value, scan index) are queued and matched on keyValid.
module tb_keypad_scan_entry;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;
  localparam int REP      = 5;

  logic        clk5;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic        keyHeld;
  logic [15:0] entryVal;

  logic [15:0] press_mask;
  logic [15:0] exp_entry;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] entry;
    int          scan;
  } exp_t;
  exp_t exp_q[$];

  // Printed keypad layout, indexed [row][col].
  localparam logic [3:0] TB_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  keypad_scan_entry #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB), .REPEAT_SCANS(REP)
  ) dut (
    .clk5(clk5), .reset(reset), .row(row), .col(col),
    .keyValid(keyValid), .keyCode(keyCode), .keyHeld(keyHeld), .entryVal(entryVal)
  );

  initial begin
    clk5 = 1'b0;
    forever #5 clk5 = ~clk5;
  end

  // Keypad model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) row = row & ~press_mask[4*c +: 4];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] key_bit(input logic [3:0] code);
    logic [15:0] m;
    m = 16'h0000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (TB_MAP[r][c] == code) m[4*c + r] = 1'b1;
    return m;
  endfunction

  // Scan counter (advances when col returns to column 0) and keyValid scoreboard.
  int         scan_cnt = 0;
  int         phase    = 0;
  logic [3:0] prev_col = 4'b1110;
  always @(negedge clk5) begin
    exp_t e;
    if (col == 4'b1110 && prev_col == 4'b0111) begin
      scan_cnt = scan_cnt + 1;
      phase    = 0;
    end else begin
      phase = phase + 1;
    end
    prev_col = col;
    if (keyValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("code", {28'd0, keyCode}, {28'd0, e.code});
        check_val("entry", {16'd0, entryVal}, {16'd0, e.entry});
        check_val("scan", scan_cnt, e.scan);
        check_val("phase", phase, 32'd1);
      end
    end
  end

  task automatic run_scans(input int n);
    int target;
    int budget;
    target = scan_cnt + n;
    budget = n * SCAN_DIV * 4 * 2 + 20;
    while (scan_cnt < target && budget > 0) begin
      @(posedge clk5); #1;
      budget--;
    end
    if (scan_cnt < target) check_val("scan_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_exp(input logic [3:0] code, input int scan);
    exp_t e;
    exp_entry = {exp_entry[11:0], code};
    e.code  = code;
    e.entry = exp_entry;
    e.scan  = scan;
    exp_q.push_back(e);
  endtask

  // Align to a scan boundary, hold one key for nscans, then release it.
  task automatic press_key(input logic [3:0] code, input int nscans);
    int s;
    run_scans(1);
    s = scan_cnt;
    if (nscans >= DB) push_exp(code, s + DB);
`ifdef KEYPAD_AUTOREPEAT_EN
    for (int j = 1; DB + REP * j <= nscans; j++) push_exp(code, s + DB + REP * j);
`endif
    press_mask = key_bit(code);
    run_scans(nscans);
    if (nscans >= DB) check_val("held", {31'd0, keyHeld}, 32'd1);
    press_mask = 16'h0000;
    run_scans(DB + 2);
    check_val("released", {31'd0, keyHeld}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    press_mask = 16'h0000;
    exp_entry  = 16'h0000;
    repeat (3) @(posedge clk5);
    #1;
    check_val("rst_col", {28'd0, col}, 32'h0000000E);
    check_val("rst_valid", {31'd0, keyValid}, 32'd0);
    check_val("rst_code", {28'd0, keyCode}, 32'd0);
    check_val("rst_held", {31'd0, keyHeld}, 32'd0);
    check_val("rst_entry", {16'd0, entryVal}, 32'd0);
    reset = 1'b0;

    // 1: idle column rotation, one column per SCAN_DIV cycles
    for (int i = 1; i <= 100; i++) begin
      logic [3:0] exp_col;
      @(posedge clk5); #1;
      exp_col = ~(4'b0001 << ((i / SCAN_DIV) % 4));
      check_val("idle_col", {28'd0, col}, {28'd0, exp_col});
    end
    check_val("idle_entry", {16'd0, entryVal}, 32'd0);

    // 2: single press of key 6
    press_key(4'h6, 6);
    check_val("code6", {28'd0, keyCode}, 32'h6);
    check_val("entry6", {16'd0, entryVal}, 32'h0006);

    // 3: sequence and wrap
    press_key(4'hA, 4);
    press_key(4'h5, 4);
    press_key(4'hF, 4);
    press_key(4'h0, 4);
    check_val("entryA5F0", {16'd0, entryVal}, 32'hA5F0);
    press_key(4'h3, 4);
    check_val("entry5F03", {16'd0, entryVal}, 32'h5F03);

    // 4: bounce on key 9, then a clean press
    run_scans(1);
    press_mask = key_bit(4'h9); run_scans(2);
    press_mask = 16'h0000;      run_scans(1);
    press_mask = key_bit(4'h9); run_scans(2);
    press_mask = 16'h0000;      run_scans(4);
    check_val("bounce_entry", {16'd0, entryVal}, 32'h5F03);
    press_key(4'h9, 3);
    check_val("code9", {28'd0, keyCode}, 32'h9);

    // 5: two keys together, then reset during debounce
    run_scans(1);
    press_mask = key_bit(4'h1) | key_bit(4'h2);
    run_scans(10);
    press_mask = 16'h0000;
    run_scans(5);
    check_val("multi_held", {31'd0, keyHeld}, 32'd0);
    check_val("multi_entry", {16'd0, entryVal}, 32'hF039);
    press_mask = key_bit(4'h1);
    run_scans(2);
    @(posedge clk5); #1;
    reset = 1'b1;
    @(posedge clk5); #1;
    press_mask = 16'h0000;
    exp_entry  = 16'h0000;
    check_val("mid_rst_col", {28'd0, col}, 32'h0000000E);
    check_val("mid_rst_valid", {31'd0, keyValid}, 32'd0);
    check_val("mid_rst_code", {28'd0, keyCode}, 32'd0);
    check_val("mid_rst_entry", {16'd0, entryVal}, 32'd0);
    repeat (2) @(posedge clk5);
    #1;
    reset = 1'b0;
    run_scans(4);
    check_val("post_rst_entry", {16'd0, entryVal}, 32'd0);

    // 6: long hold of key C
    press_key(4'hC, 20);
`ifdef KEYPAD_AUTOREPEAT_EN
    check_val("repeat_entry", {16'd0, entryVal}, 32'hCCCC);
`else
    check_val("single_entry", {16'd0, entryVal}, 32'h000C);
`endif

    check_val("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
